// File: rtl/credit_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : credit_fifo_pkg
// Brief  : Shared constants, error-cause type and clog2 helper for credit_fifo.
// Rev    : 1.0 - initial release
// ============================================================================
package credit_fifo_pkg;

    localparam int c_default_width   = 32;
    localparam int c_default_latency = 3;
    localparam int c_default_depth   = 8;

    // One bit per protocol violation; any set bit latches the sticky error.
    typedef struct packed {
        logic credit_overrun;  // issue without a free credit
        logic spurious_valid;  // din_valid with nothing in flight
        logic overflow;        // din_valid into a full buffer with no pop
    } err_cause_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : credit_fifo_pkg
`default_nettype wire

// File: rtl/credit_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module : credit_fifo_mem
// Brief  : DEPTH x WIDTH simple-dual-port RAM, synchronous write, async read.
// Rev    : 1.0 - initial release
// ============================================================================
module credit_fifo_mem #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read gives first-word-fall-through at the top level.
    assign rd_data = r_mem[rd_addr];

endmodule : credit_fifo_mem
`default_nettype wire

// File: rtl/credit_fifo.sv
`default_nettype none
// ============================================================================
// Module : credit_fifo
// Brief  : Credit-gated receive buffer for unstallable fixed-latency pipes.
// Rev    : 1.0 - initial release
// ============================================================================
module credit_fifo
    import credit_fifo_pkg::*;
#(
    parameter int WIDTH   = c_default_width,
    parameter int LATENCY = c_default_latency,
    parameter int DEPTH   = c_default_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  issue_ok,
    input  logic                  issue,
    input  logic                  din_valid,
    input  logic [WIDTH-1:0]      din,
    output logic                  dout_valid,
    output logic [WIDTH-1:0]      dout,
    input  logic                  dout_ready,
    output logic [clog2(DEPTH):0] count,
    output logic                  err
);

    localparam int c_addr_w = clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  r_inflight;
    logic                r_err;
    logic [LATENCY-1:0]  r_issue_hist;

    logic [c_cnt_w-1:0]  w_count_nxt;
    logic [c_cnt_w-1:0]  w_inflight_nxt;
    logic [c_cnt_w:0]    w_credits_used;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_credit_ok;
    logic                w_inflight_dec;
    err_cause_t          w_cause;

    assign w_full         = (r_count == c_depth);
    assign w_pop          = (r_count != '0) && dout_ready;
    // A pop in the same cycle makes room, so a full buffer still accepts.
    assign w_push         = din_valid && (!w_full || w_pop);
    assign w_credits_used = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit_ok    = (w_credits_used < {1'b0, c_depth});
    assign w_inflight_dec = din_valid && (r_inflight != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Saturates at both ends so protocol abuse cannot wrap the credit count.
    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({issue, w_inflight_dec})
            2'b10: begin
                if (r_inflight != '1) begin
                    w_inflight_nxt = r_inflight + c_cnt_one;
                end
            end
            2'b01:   w_inflight_nxt = r_inflight - c_cnt_one;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_comb begin
        w_cause                = '0;
        w_cause.credit_overrun = issue && !w_credit_ok;
        w_cause.spurious_valid = din_valid && (r_inflight == '0);
        w_cause.overflow       = din_valid && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_err      <= r_err | (|w_cause);
        end
    end

    // Issue history used only to check that every issue returns on time.
    generate
        if (LATENCY > 1) begin : g_hist_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_issue_hist <= '0;
                end else begin
                    r_issue_hist <= {r_issue_hist[LATENCY-2:0], issue};
                end
            end
        end else begin : g_hist_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_issue_hist <= '0;
                end else begin
                    r_issue_hist <= issue;
                end
            end
        end
    endgenerate

    always @(posedge clk) begin
        if (!rst && r_issue_hist[LATENCY-1]) begin
            assert (din_valid);
        end
    end

    credit_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (din),
        .rd_addr (r_rd_ptr),
        .rd_data (dout)
    );

    assign issue_ok   = w_credit_ok;
    assign dout_valid = (r_count != '0);
    assign count      = r_count;
    assign err        = r_err;

endmodule : credit_fifo
`default_nettype wire
